// File: rtl/rv32_pkg.sv
// Shared constants for the RV32 decode / ID-EX stage: ALU opsel encoding,
// base-ISA opcodes and funct3/funct7 field values.
package rv32_pkg;

    typedef enum logic [3:0] {
        OPSEL_ADD   = 4'd0,
        OPSEL_SUB   = 4'd1,
        OPSEL_AND   = 4'd2,
        OPSEL_OR    = 4'd3,
        OPSEL_XOR   = 4'd4,
        OPSEL_SLT   = 4'd5,
        OPSEL_SLTU  = 4'd6,
        OPSEL_ADDI  = 4'd7,
        OPSEL_LOAD  = 4'd8,
        OPSEL_ANDI  = 4'd9,
        OPSEL_ORI   = 4'd10,
        OPSEL_XORI  = 4'd11,
        OPSEL_SLTI  = 4'd12,
        OPSEL_SLTIU = 4'd13,
        OPSEL_LUI   = 4'd14,
        OPSEL_AUIPC = 4'd15
    } alu_opsel_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/rv32_alu_decode.sv
// Combinational instruction classifier: ALU opsel, ALU-class flag, load flag,
// rd write enable (never for x0 or illegal encodings) and illegal flag.
module rv32_alu_decode
    import rv32_pkg::*;
(
    input  logic [31:0] instr_i,
    output alu_opsel_e  opsel_o,
    output logic        alu_class_o,
    output logic        is_load_o,
    output logic        rd_we_o,
    output logic        illegal_o
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;
    logic       rd_we_raw;
    logic       instr_unused;

    assign opcode       = instr_i[6:0];
    assign f3           = instr_i[14:12];
    assign f7           = instr_i[31:25];
    assign rd           = instr_i[11:7];
    assign instr_unused = ^instr_i[24:15];

    // Classify by opcode, then refine by funct3/funct7
    always_comb begin
        opsel_o     = OPSEL_ADD;
        alu_class_o = 1'b0;
        is_load_o   = 1'b0;
        rd_we_raw   = 1'b0;
        illegal_o   = 1'b0;
        unique case (opcode)
            OPC_OP: begin
                rd_we_raw = 1'b1;
                if (f7 == F7_BASE) begin
                    alu_class_o = 1'b1;
                    unique case (f3)
                        F3_ADD_SUB: opsel_o = OPSEL_ADD;
                        F3_SLT:     opsel_o = OPSEL_SLT;
                        F3_SLTU:    opsel_o = OPSEL_SLTU;
                        F3_XOR:     opsel_o = OPSEL_XOR;
                        F3_OR:      opsel_o = OPSEL_OR;
                        F3_AND:     opsel_o = OPSEL_AND;
                        default:    alu_class_o = 1'b0;  // SLL / SRL
                    endcase
                end else if (f7 == F7_ALT && f3 == F3_ADD_SUB) begin
                    alu_class_o = 1'b1;
                    opsel_o     = OPSEL_SUB;
                end else if (!(f7 == F7_ALT && f3 == F3_SR)) begin
                    illegal_o = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                rd_we_raw   = 1'b1;
                alu_class_o = 1'b1;
                unique case (f3)
                    F3_ADD_SUB: opsel_o = OPSEL_ADDI;
                    F3_SLT:     opsel_o = OPSEL_SLTI;
                    F3_SLTU:    opsel_o = OPSEL_SLTIU;
                    F3_XOR:     opsel_o = OPSEL_XORI;
                    F3_OR:      opsel_o = OPSEL_ORI;
                    F3_AND:     opsel_o = OPSEL_ANDI;
                    F3_SLL: begin
                        alu_class_o = 1'b0;
                        illegal_o   = (f7 != F7_BASE);
                    end
                    default: begin
                        alu_class_o = 1'b0;
                        illegal_o   = (f7 != F7_BASE) && (f7 != F7_ALT);
                    end
                endcase
            end
            OPC_LOAD: begin
                rd_we_raw   = 1'b1;
                is_load_o   = 1'b1;
                alu_class_o = 1'b1;
                opsel_o     = OPSEL_LOAD;
                illegal_o   = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OPC_LUI: begin
                rd_we_raw   = 1'b1;
                alu_class_o = 1'b1;
                opsel_o     = OPSEL_LUI;
            end
            OPC_AUIPC: begin
                rd_we_raw   = 1'b1;
                alu_class_o = 1'b1;
                opsel_o     = OPSEL_AUIPC;
            end
            OPC_STORE:  illegal_o = (f3 > 3'b010);
            OPC_BRANCH: illegal_o = (f3 == 3'b010) || (f3 == 3'b011);
            OPC_JAL:    rd_we_raw = 1'b1;
            OPC_JALR: begin
                rd_we_raw = 1'b1;
                illegal_o = (f3 != 3'b000);
            end
            OPC_SYSTEM: begin
                rd_we_raw = (f3 != 3'b000);
                illegal_o = (f3 == 3'b100);
            end
            default: illegal_o = 1'b1;
        endcase
        if (illegal_o) begin
            opsel_o     = OPSEL_ADD;
            alu_class_o = 1'b0;
            is_load_o   = 1'b0;
        end
        rd_we_o = rd_we_raw && !illegal_o && (rd != 5'd0);
    end

endmodule

// File: rtl/rv32_id_ex_stage.sv
// RV32 decode stage plus ID/EX pipeline register.
// Optional writeback bypass: define RV32_ID_WB_BYPASS_EN. Without it, a
// same-cycle writeback to a source register stalls decode for one cycle.
module rv32_id_ex_stage
    import rv32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic        id_ready,
    output logic [4:0]  rf_rs1_addr,
    output logic [4:0]  rf_rs2_addr,
    input  logic [31:0] rf_rs1_data,
    input  logic [31:0] rf_rs2_data,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        ex_stall,
    input  logic        flush,
    output logic        ex_valid,
    output logic        ex_enable,
    output logic [3:0]  ex_alu_opsel,
    output logic [31:0] ex_reg_s1,
    output logic [31:0] ex_reg_s2,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_code_bus,
    output logic [4:0]  ex_rd,
    output logic        ex_rd_we,
    output logic        ex_is_load,
    output logic        ex_illegal
);

    alu_opsel_e  dec_opsel;
    logic        dec_alu_class, dec_is_load, dec_rd_we, dec_illegal;
    logic [4:0]  rs1, rs2;
    logic [31:0] op_s1, op_s2;
    logic        wb_block, load_use, accept, is_op;

    logic        valid_q, valid_d, enable_q, enable_d;
    alu_opsel_e  opsel_q, opsel_d;
    logic [31:0] s1_q, s1_d, s2_q, s2_d, pc_q, pc_d, code_q, code_d;
    logic [4:0]  rd_q, rd_d;
    logic        rd_we_q, rd_we_d, is_load_q, is_load_d, illegal_q, illegal_d;

    assign rs1         = if_instr[19:15];
    assign rs2         = if_instr[24:20];
    assign rf_rs1_addr = rs1;
    assign rf_rs2_addr = rs2;
    assign is_op       = (if_instr[6:0] == OPC_OP);

    rv32_alu_decode u_dec (
        .instr_i     (if_instr),
        .opsel_o     (dec_opsel),
        .alu_class_o (dec_alu_class),
        .is_load_o   (dec_is_load),
        .rd_we_o     (dec_rd_we),
        .illegal_o   (dec_illegal)
    );

`ifdef RV32_ID_WB_BYPASS_EN
    // Forward the writeback value over stale register-file data; x0 excluded
    always_comb begin
        op_s1    = (wb_we && wb_rd != 5'd0 && wb_rd == rs1) ? wb_data : rf_rs1_data;
        op_s2    = (wb_we && wb_rd != 5'd0 && wb_rd == rs2) ? wb_data : rf_rs2_data;
        wb_block = 1'b0;
    end
`else
    logic wb_data_unused;
    assign wb_data_unused = ^wb_data;

    // No bypass: hold decode for a cycle until the write lands in the file
    always_comb begin
        op_s1    = rf_rs1_data;
        op_s2    = rf_rs2_data;
        wb_block = wb_we && (wb_rd != 5'd0) && ((wb_rd == rs1) || (wb_rd == rs2));
    end
`endif

    // Load-use interlock, ready and accept
    always_comb begin
        load_use = valid_q && is_load_q && (rd_q != 5'd0) &&
                   ((rd_q == rs1) || (is_op && rd_q == rs2));
        id_ready = rst_n && !ex_stall && !load_use && !wb_block;
        accept   = if_valid && id_ready && !flush;
    end

    // EX register next state: flush > stall hold > accept > bubble
    always_comb begin
        valid_d   = valid_q;
        enable_d  = enable_q;
        opsel_d   = opsel_q;
        s1_d      = s1_q;
        s2_d      = s2_q;
        pc_d      = pc_q;
        code_d    = code_q;
        rd_d      = rd_q;
        rd_we_d   = rd_we_q;
        is_load_d = is_load_q;
        illegal_d = illegal_q;
        if (flush || (!ex_stall && !accept)) begin
            valid_d   = 1'b0;
            enable_d  = 1'b0;
            rd_we_d   = 1'b0;
            is_load_d = 1'b0;
            illegal_d = 1'b0;
        end else if (accept) begin
            valid_d   = 1'b1;
            enable_d  = dec_alu_class;
            opsel_d   = dec_opsel;
            s1_d      = op_s1;
            s2_d      = op_s2;
            pc_d      = if_pc;
            code_d    = if_instr;
            rd_d      = if_instr[11:7];
            rd_we_d   = dec_rd_we;
            is_load_d = dec_is_load;
            illegal_d = dec_illegal;
        end
    end

    // EX register, cleared asynchronously on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            enable_q  <= 1'b0;
            opsel_q   <= OPSEL_ADD;
            s1_q      <= '0;
            s2_q      <= '0;
            pc_q      <= '0;
            code_q    <= '0;
            rd_q      <= '0;
            rd_we_q   <= 1'b0;
            is_load_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            enable_q  <= enable_d;
            opsel_q   <= opsel_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            pc_q      <= pc_d;
            code_q    <= code_d;
            rd_q      <= rd_d;
            rd_we_q   <= rd_we_d;
            is_load_q <= is_load_d;
            illegal_q <= illegal_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_enable    = enable_q;
    assign ex_alu_opsel = opsel_q;
    assign ex_reg_s1    = s1_q;
    assign ex_reg_s2    = s2_q;
    assign ex_pc        = pc_q;
    assign ex_code_bus  = code_q;
    assign ex_rd        = rd_q;
    assign ex_rd_we     = rd_we_q;
    assign ex_is_load   = is_load_q;
    assign ex_illegal   = illegal_q;

endmodule
